// File: rtl/instr_loader_pkg.sv
// Shared defaults and framer state encoding for the serial instruction loader.
package instr_loader_pkg;

    localparam int unsigned WIDTH_DEF = 9;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } framer_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead instruction queue; a push while full is accepted only alongside a pop.
module instr_fifo
    import instr_loader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        // Power-of-two depth lets the pointers wrap by plain overflow.
        wptr_d  = wptr_q + PtrW'(do_push);
        rptr_d  = rptr_q + PtrW'(do_pop);
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/instr_loader.sv
// Serial-to-parallel instruction framer feeding a show-ahead queue toward the CPU.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     SER_IN,
    input  logic                     SER_VALID,
    input  logic                     SER_SYNC,
    input  logic                     STALL,
    output logic [WIDTH-1:0]         INSTRUCTION,
    output logic                     write_en,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     OVERFLOW
);
    localparam int unsigned BitW = $clog2(WIDTH);
    localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

    framer_state_e    state_q, state_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shifted;
    logic             ovf_q, ovf_d;
    logic             push;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        shifted   = {shift_q[WIDTH-2:0], SER_IN};
        unique case (state_q)
            StIdle: begin
                if (SER_SYNC) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            StShift: begin
                // Sync re-frames: partial word is thrown away and the bit is ignored.
                if (SER_SYNC) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (SER_VALID) begin
                    if (bit_cnt_q == LastBit) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        shift_d   = shifted;
                    end
                end
            end
        endcase
    end

    always_comb begin
        write_en = ~EMPTY & ~STALL;
        ovf_d    = ovf_q | (push & FULL & ~write_en);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ovf_q     <= ovf_d;
        end
    end

    assign OVERFLOW = ovf_q;

    instr_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .push_i  (push),
        .pop_i   (write_en),
        .data_i  (shifted),
        .data_o  (INSTRUCTION),
        .count_o (COUNT),
        .full_o  (FULL),
        .empty_o (EMPTY)
    );

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, directed corner sequences, random run.
module tb_instr_loader;
    localparam int W = 9;
    localparam int D = 4;

    logic         CLK, RESET, SER_IN, SER_VALID, SER_SYNC, STALL;
    logic [W-1:0] INSTRUCTION;
    logic         write_en;
    logic [2:0]   COUNT;
    logic         FULL, EMPTY, OVERFLOW;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a word queue plus a simple bit accumulator.
    logic [W-1:0] mq[$];
    bit           m_framing;
    int           m_nbits;
    int           m_acc;
    bit           m_ovf;

    typedef struct {
        logic         sync, valid, din, stall;
        logic [W-1:0] instr;
        logic         we;
        logic [2:0]   count;
        logic         empty, full, ovf;
    } vec_t;

    vec_t vecs[12];

    instr_loader #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SER_IN      (SER_IN),
        .SER_VALID   (SER_VALID),
        .SER_SYNC    (SER_SYNC),
        .STALL       (STALL),
        .INSTRUCTION (INSTRUCTION),
        .write_en    (write_en),
        .COUNT       (COUNT),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .OVERFLOW    (OVERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mkv(input logic s, input logic v, input logic d, input logic st,
                                 input logic [W-1:0] i, input logic we, input logic [2:0] c,
                                 input logic e, input logic f, input logic o);
        vec_t r;
        r.sync = s; r.valid = v; r.din = d; r.stall = st;
        r.instr = i; r.we = we; r.count = c; r.empty = e; r.full = f; r.ovf = o;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_framing = 1'b0;
        m_nbits   = 0;
        m_acc     = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_edge();
        bit pop, push;
        int pw;
        pop  = (mq.size() != 0) && !STALL;
        push = 1'b0;
        pw   = 0;
        if (!m_framing) begin
            if (SER_SYNC) begin
                m_framing = 1'b1;
                m_nbits   = 0;
                m_acc     = 0;
            end
        end else if (SER_SYNC) begin
            m_nbits = 0;
            m_acc   = 0;
        end else if (SER_VALID) begin
            m_acc = ((m_acc << 1) | int'(SER_IN)) & ((1 << W) - 1);
            m_nbits++;
            if (m_nbits == W) begin
                push    = 1'b1;
                pw      = m_acc;
                m_nbits = 0;
                m_acc   = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < D) mq.push_back(W'(pw));
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [W-1:0] ei;
        int sz;
        sz = mq.size();
        ei = (sz != 0) ? mq[0] : '0;
        chk("instr", 32'(INSTRUCTION), 32'(ei));
        chk("write_en", 32'(write_en), 32'((sz != 0) && !STALL));
        chk("count", 32'(COUNT), 32'(sz));
        chk("full", 32'(FULL), 32'(sz == D));
        chk("empty", 32'(EMPTY), 32'(sz == 0));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
    endtask

    task automatic drive(input logic s, input logic v, input logic d, input logic st);
        SER_SYNC = s; SER_VALID = v; SER_IN = d; STALL = st;
    endtask

    task automatic step(input logic s, input logic v, input logic d, input logic st);
        drive(s, v, d, st);
        @(negedge CLK);
        check_model();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic st_body, input logic st_last);
        for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, w[i], (i == 0) ? st_last : st_body);
    endtask

    // Called at posedge+1; pulses reset mid-cycle and checks the forced outputs.
    task automatic reset_dut();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        #1;
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_instr", 32'(INSTRUCTION), 32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_ovf", 32'(OVERFLOW), 32'd0);
        model_reset();
        #1 RESET = 1'b1;
    endtask

    initial begin
        logic [W-1:0] w125;
        logic [W-1:0] words[5];
        logic         st;

        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #7;
        chk("init_empty", 32'(EMPTY), 32'd1);
        chk("init_full", 32'(FULL), 32'd0);
        chk("init_we", 32'(write_en), 32'd0);
        chk("init_instr", 32'(INSTRUCTION), 32'd0);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Vector table: sync, 9'h125 MSB first, then head visible for one cycle.
        w125 = 9'h125;
        vecs[0] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < W; i++)
            vecs[i+1] = mkv(1'b0, 1'b1, w125[W-1-i], 1'b0, 9'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        vecs[10] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 9'h125, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].sync, vecs[i].valid, vecs[i].din, vecs[i].stall);
            @(negedge CLK);
            chk("tbl_instr", 32'(INSTRUCTION), 32'(vecs[i].instr));
            chk("tbl_we", 32'(write_en), 32'(vecs[i].we));
            chk("tbl_count", 32'(COUNT), 32'(vecs[i].count));
            chk("tbl_empty", 32'(EMPTY), 32'(vecs[i].empty));
            chk("tbl_full", 32'(FULL), 32'(vecs[i].full));
            chk("tbl_ovf", 32'(OVERFLOW), 32'(vecs[i].ovf));
            @(posedge CLK);
            model_edge();
            #1;
        end

        // Stalled stream of five words: fifth dropped, first four drain in order.
        reset_dut();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            words[k] = W'($urandom);
            send_word(words[k], 1'b1, 1'b1);
            if (k == 3) begin
                chk("s34_full4", 32'(FULL), 32'd1);
                chk("s34_ovf4", 32'(OVERFLOW), 32'd0);
            end
        end
        chk("s34_ovf", 32'(OVERFLOW), 32'd1);
        chk("s34_count", 32'(COUNT), 32'd4);
        for (int k = 0; k < 4; k++) begin
            STALL = 1'b0;
            #1 chk("s34_order", 32'(INSTRUCTION), 32'(words[k]));
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("s34_drained", 32'(EMPTY), 32'd1);
        chk("s34_sticky", 32'(OVERFLOW), 32'd1);

        // Push on a pop edge while full: accepted, new word last out.
        reset_dut();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            words[k] = W'($urandom);
            send_word(words[k], 1'b1, (k == 4) ? 1'b0 : 1'b1);
        end
        chk("s35_count", 32'(COUNT), 32'd4);
        chk("s35_ovf", 32'(OVERFLOW), 32'd0);
        for (int k = 1; k < 5; k++) begin
            STALL = 1'b0;
            #1 chk("s35_order", 32'(INSTRUCTION), 32'(words[k]));
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("s35_drained", 32'(EMPTY), 32'd1);

        // Re-sync after a partial word discards the partial bits.
        reset_dut();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom), 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_word(9'h0AA, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s36_count", 32'(COUNT), 32'd1);
        chk("s36_instr", 32'(INSTRUCTION), 32'h0AA);

        // Reset mid-queue and mid-word; no framing until a new sync.
        reset_dut();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_word(W'($urandom), 1'b1, 1'b1);
        send_word(W'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'($urandom), 1'b1);
        chk("s37_pre", 32'(COUNT), 32'd2);
        reset_dut();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
        chk("s37_empty", 32'(EMPTY), 32'd1);
        chk("s37_count", 32'(COUNT), 32'd0);

        // Gapped bits over ten words with random stalls to wrap the pointers.
        reset_dut();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            for (int i = W - 1; i >= 0; i--) begin
                repeat ($urandom_range(1, 3)) begin
                    st = ($urandom_range(0, 3) == 0);
                    step(1'b0, 1'b0, 1'($urandom), st);
                end
                st = ($urandom_range(0, 3) == 0);
                step(1'b0, 1'b1, w[i], st);
            end
        end
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Fully random traffic.
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 2) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 9, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue depth in entries (power of two).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SER_IN  input  1  serial instruction bit, MSB first.
REQ-006 SHALL have port SER_VALID  input  1  SER_IN carries a valid bit this cycle.
REQ-007 SHALL have port SER_SYNC  input  1  framing strobe; starts a new word boundary.
REQ-008 SHALL have port STALL  input  1  downstream CPU cannot accept an instruction this cycle.
REQ-009 SHALL have port INSTRUCTION  output  WIDTH  head-of-queue instruction to the CPU.
REQ-010 SHALL have port write_en  output  1  INSTRUCTION valid and consumed this cycle.
REQ-011 SHALL have port COUNT  output  log2(DEPTH)+1  current queue occupancy.
REQ-012 SHALL have port FULL  output  1  COUNT equals DEPTH.
REQ-013 SHALL have port EMPTY  output  1  COUNT equals 0.
REQ-014 SHALL have port OVERFLOW  output  1  sticky flag: a completed word was dropped.

Function
REQ-015 SHALL implement a two-state framer FSM: IDLE, SHIFT.
REQ-016 In IDLE, SER_VALID SHALL be ignored; SER_SYNC high SHALL move to SHIFT with the bit counter at 0.
REQ-017 In SHIFT, SER_SYNC high SHALL clear the bit counter, discard the partial word, and ignore SER_VALID that cycle; the FSM stays in SHIFT.
REQ-018 In SHIFT with SER_VALID high and SER_SYNC low, the shift register SHALL shift left, take SER_IN into bit 0, and increment the bit counter.
REQ-019 On the edge capturing bit WIDTH-1, i.e. the 9th bit, the complete word SHALL be pushed into the queue, the counter SHALL return to 0, and the FSM stays in SHIFT for back-to-back words.
REQ-020 If the queue is full and no pop occurs on the push edge, the word SHALL be dropped and OVERFLOW set; OVERFLOW clears only on reset.
REQ-021 A push and a pop on the same edge while full SHALL both succeed, leaving COUNT unchanged.
REQ-022 The queue SHALL be show-ahead: INSTRUCTION equals the head entry whenever EMPTY is low, and all-zeros when EMPTY is high.
REQ-023 write_en SHALL be combinationally (!EMPTY && !STALL); a pop occurs on every edge where write_en is high.
REQ-024 There SHALL be no empty-queue bypass: a word pushed into an empty queue appears on INSTRUCTION, with write_en able to assert, in the cycle after the push edge (latency 1 cycle).
REQ-025 A push and a pop on the same edge with COUNT=1 SHALL leave COUNT=1, with the new word at the head.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; COUNT SHALL never exceed DEPTH or underflow.
REQ-027 FULL, EMPTY and COUNT SHALL be registered-state derived and glitch-free relative to CLK.

Reset
REQ-028 RESET low SHALL immediately force: FSM to IDLE, bit counter and shift register to 0, pointers and COUNT to 0, OVERFLOW to 0.
REQ-029 While RESET is low, the outputs SHALL be: EMPTY=1, FULL=0, write_en=0, INSTRUCTION=0.
REQ-030 Reset asserted mid-word or mid-queue SHALL discard all partial and queued instructions; operation resumes only after a new SER_SYNC.

Structure
REQ-031 A shared package SHALL hold WIDTH and DEPTH defaults and the framer state encoding (IDLE=0, SHIFT=1).
REQ-032 The queue SHALL be a sub-module instr_fifo (push, pop, data, count, full, empty); the framer and overflow logic stay in instr_loader.

Verification
REQ-033 Reset, SER_SYNC, 9 bits 1_0010_0101 -> next cycle INSTRUCTION=9'h125, write_en=1, COUNT=1; following cycle EMPTY=1.
REQ-034 STALL=1, five words streamed back-to-back -> FULL after the 4th, 5th dropped, OVERFLOW=1; release STALL -> first 4 words pop in order.
REQ-035 Full queue, STALL=0, 9th bit edge coincides with a pop -> COUNT stays 4, OVERFLOW stays 0, new word is last out.
REQ-036 SER_SYNC after 5 bits, then 9 bits of 9'h0AA -> only 9'h0AA is queued; partial bits discarded.
REQ-037 RESET low asserted after 2 queued words plus 4 bits -> EMPTY=1, write_en=0 immediately; SER_VALID without SER_SYNC after release -> nothing queued.
REQ-038 SER_VALID gaps (bits spaced 1-3 idle cycles) -> word assembled correctly, pointer wrap verified over 10 words.
